pmod_input_conditioner: RTL



---
 rtl/pmod_ioc_pkg.sv | 18 +
 rtl/pmod_ioc_channel.sv | 79 +++++++
 rtl/pmod_input_conditioner.sv | 43 ++++
 3 files changed

// File: rtl/pmod_ioc_pkg.sv
// Shared types, default parameters and sizing helper for the PMOD input conditioner.
package pmod_ioc_pkg;

  typedef enum logic {
    IOC_LEVEL  = 1'b0,
    IOC_TOGGLE = 1'b1
  } ioc_mode_e;

  localparam int IOC_N_CH_DEF            = 8;
  localparam int IOC_SYNC_STAGES_DEF     = 2;
  localparam int IOC_DEBOUNCE_CYCLES_DEF = 16;

  // Counter only needs to reach cycles-1, but this sizing keeps cycles=1 legal.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pmod_ioc_channel.sv
// One conditioned input: synchroniser, debounce counter, edge pulses and
// toggle state, with a level/toggle output mux.
module pmod_ioc_channel
  import pmod_ioc_pkg::*;
#(
  parameter int SYNC_STAGES     = IOC_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = IOC_DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic x_in,
  input  logic mode_toggle,
  input  logic clear_toggle,
  output logic out,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int             CW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   tog_q, tog_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], x_in};
    s      = sync_q[SYNC_STAGES-1];
    cnt_d  = cnt_q;
    db_d   = db_q;
    tog_d  = tog_q;
    rise_d = 1'b0;
    fall_d = 1'b0;

    if (s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      db_d   = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (rise_d) tog_d = ~tog_q;
    // Clear has priority over a coincident press; the rise pulse is unaffected.
    if (clear_toggle) tog_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      tog_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      tog_q  <= tog_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = (ioc_mode_e'(mode_toggle) == IOC_TOGGLE) ? tog_q : db_q;
  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pmod_input_conditioner.sv
// Board-pin input path: static polarity inversion, then N_CH independent
// conditioned channels feeding the design under test.
module pmod_input_conditioner
  import pmod_ioc_pkg::*;
#(
  parameter int              N_CH            = IOC_N_CH_DEF,
  parameter int              SYNC_STAGES     = IOC_SYNC_STAGES_DEF,
  parameter int              DEBOUNCE_CYCLES = IOC_DEBOUNCE_CYCLES_DEF,
  parameter logic [N_CH-1:0] INVERT          = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  input  logic [N_CH-1:0] mode_toggle,
  input  logic            clear_toggle,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  // Active-low pins become active-high before entering the synchroniser.
  logic [N_CH-1:0] x;
  assign x = raw_in ^ INVERT;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pmod_ioc_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .x_in        (x[i]),
      .mode_toggle (mode_toggle[i]),
      .clear_toggle(clear_toggle),
      .out         (out[i]),
      .db          (db[i]),
      .rise        (rise[i]),
      .fall        (fall[i])
    );
  end

endmodule
